// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that shares the single write port of an
// async FIFO among NREQ requesters. Runs entirely in the write clock domain.
// The grant is combinational, so a word is written on the same wclk edge
// where req_valid & req_ready are both high.
// Optional packet locking: define FIFO_ARB_PKTLOCK_EN to keep the grant
// with one requester until the beat that has req_last set.
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*DSIZE-1:0]         req_data,
    input  logic [NREQ-1:0]               req_last,
    output logic [NREQ-1:0]               req_ready,
    output logic                          winc,
    output logic [DSIZE-1:0]              wdata,
    input  logic                          wfull,
    output logic [$clog2(NREQ)-1:0]       gnt_id,
    output logic [CNTW-1:0]               wcount
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]    ptr_reg;
    logic [CNTW-1:0]  count_reg;
    logic [NREQ-1:0]  eligible;
    logic [IW-1:0]    winner;
    logic             found;
    logic             xfer;
    logic [IW-1:0]    ptr_next;
    logic [DSIZE-1:0] slices [NREQ];

`ifdef FIFO_ARB_PKTLOCK_EN
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_reg;
    logic [IW-1:0]   owner_reg;

    // While a packet is in flight only its owner may compete for the port.
    always_comb begin
        eligible = req_valid;
        if (state_reg == LOCKED) begin
            eligible = '0;
            eligible[owner_reg] = req_valid[owner_reg];
        end
    end

    // Packet-lock FSM: lock on a non-final beat, unlock on the final beat.
    // A stalled write (wfull) produces no xfer, so the FSM holds in place.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg <= IDLE;
            owner_reg <= '0;
        end else if (xfer) begin
            case (state_reg)
                IDLE: begin
                    if (!req_last[winner]) begin
                        state_reg <= LOCKED;
                        owner_reg <= winner;
                    end
                end
                LOCKED: begin
                    if (req_last[owner_reg]) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
`else
    // Without packet locking every beat is re-arbitrated and req_last is unused.
    logic unused_last;
    assign unused_last = ^req_last;
    assign eligible    = req_valid;
`endif

    // Scan from ptr upward (mod NREQ) and pick the first eligible requester.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

    // Reset gates the handshake immediately, without waiting for a clock.
    assign xfer     = found & ~wfull & wrst_n;
    assign winc     = xfer;
    assign gnt_id   = winner;
    assign wcount   = count_reg;
    assign ptr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign slices[gi]    = req_data[gi*DSIZE +: DSIZE];
            assign req_ready[gi] = xfer && (winner == IW'(gi));
        end
    endgenerate

    assign wdata = slices[winner];

    // Advance the round-robin pointer past the winner and count written words.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (xfer) begin
            ptr_reg <= ptr_next;
            if (count_reg != {CNTW{1'b1}}) begin
                count_reg <= count_reg + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed testbench for fifo_wr_arb. Inputs change 1ns after the rising
// edge; combinational outputs are checked on the falling edge and counters
// 1ns after the rising edge. A second instance with CNTW=4 shares the
// inputs and is used for the saturation check.
module tb_fifo_wr_arb;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        winc;
    logic [7:0]  wdata;
    logic        wfull;
    logic [1:0]  gnt_id;
    logic [15:0] wcount;

    logic [3:0]  req_ready4;
    logic        winc4;
    logic [7:0]  wdata4;
    logic [1:0]  gnt_id4;
    logic [3:0]  wcount4;

    int checks = 0;
    int errors = 0;

    always #5 wclk = ~wclk;

    fifo_wr_arb #(.NREQ(4), .DSIZE(8), .CNTW(16)) u_dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .winc(winc), .wdata(wdata),
        .wfull(wfull), .gnt_id(gnt_id), .wcount(wcount)
    );

    fifo_wr_arb #(.NREQ(4), .DSIZE(8), .CNTW(4)) u_dut4 (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready4), .winc(winc4), .wdata(wdata4),
        .wfull(wfull), .gnt_id(gnt_id4), .wcount(wcount4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n    = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        wfull     = 1'b0;
        repeat (2) tick();
        wrst_n = 1'b1;
    endtask

    initial begin
        int sent1;
        logic [1:0] order [4];
        wrst_n    = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        wfull     = 1'b0;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // 1. Reset state, then valids raised while still in reset stay gated
        tick();
        @(negedge wclk);
        chk("rst_winc",   32'(winc),      32'h0);
        chk("rst_ready",  32'(req_ready), 32'h0);
        chk("rst_gnt",    32'(gnt_id),    32'h0);
        chk("rst_wcount", 32'(wcount),    32'h0);
        req_valid = 4'b1111;
        #1;
        chk("rst_gate_ready", 32'(req_ready), 32'h0);
        chk("rst_gate_winc",  32'(winc),      32'h0);

        // 2. All requesters valid: strict rotation A0..A3, A0
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            chk("rr_winc",  32'(winc),  32'h1);
            chk("rr_wdata", 32'(wdata), 32'hA0 + 32'(k % 4));
            chk("rr_gnt",   32'(gnt_id), 32'(k % 4));
            chk("rr_ready", 32'(req_ready), 32'h1 << (k % 4));
            tick();
        end
        chk("rr_wcount", 32'(wcount), 32'd5);
        req_valid = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge wclk);
            chk("idle_gnt",  32'(gnt_id), 32'h0);
            chk("idle_winc", 32'(winc),   32'h0);
            tick();
        end
        chk("idle_wcount", 32'(wcount), 32'd5);
        req_valid = 4'b1111;
        @(negedge wclk);
        chk("idle_ptr_held", 32'(gnt_id), 32'h1);

        // 3. wfull stalls the handshake and the pointer
        do_reset();
        req_valid = 4'b0001;
        wfull     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            chk("full_winc",  32'(winc),      32'h0);
            chk("full_ready", 32'(req_ready), 32'h0);
            tick();
        end
        chk("full_wcount", 32'(wcount), 32'h0);
        wfull = 1'b0;
        @(negedge wclk);
        chk("unfull_winc",  32'(winc),      32'h1);
        chk("unfull_wdata", 32'(wdata),     32'hA0);
        chk("unfull_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b1111;
        @(negedge wclk);
        chk("unfull_ptr", 32'(gnt_id), 32'h1);

        // 4. req1 sends a 3-beat packet while req2 stays valid
        do_reset();
`ifdef FIFO_ARB_PKTLOCK_EN
        order = '{2'd1, 2'd1, 2'd1, 2'd2};
`else
        order = '{2'd1, 2'd2, 2'd1, 2'd2};
`endif
        sent1 = 0;
        for (int k = 0; k < 4; k++) begin
            req_valid   = {1'b0, 1'b1, (sent1 < 3), 1'b0};
            req_last    = {2'b00, (sent1 == 2), 1'b0};
            req_data    = {8'hA3, 8'hC0, 8'hB0 + 8'(sent1), 8'hA0};
            @(negedge wclk);
            chk("pkt_gnt", 32'(gnt_id), 32'(order[k]));
            chk("pkt_wdata", 32'(wdata), (order[k] == 2'd1) ? 32'hB0 + 32'(sent1) : 32'hC0);
            if (req_ready[1]) sent1++;
            tick();
        end
        chk("pkt_wcount", 32'(wcount), 32'd4);
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_last = 4'b0000;

        // 5. Saturating counter on the CNTW=4 instance
        do_reset();
        req_valid = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) chk("sat_cnt10", 32'(wcount4), 32'hA);
            if (k == 15) chk("sat_cnt15", 32'(wcount4), 32'hF);
        end
        chk("sat_cnt20",  32'(wcount4), 32'hF);
        chk("wide_cnt20", 32'(wcount),  32'd20);

        // 6. Asynchronous reset in the middle of a packet
        do_reset();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        @(negedge wclk);
        chk("lk_first_gnt", 32'(gnt_id), 32'h1);
        tick();
        req_valid = 4'b1111;
        @(negedge wclk);
`ifdef FIFO_ARB_PKTLOCK_EN
        chk("lk_locked_gnt", 32'(gnt_id), 32'h1);
`else
        chk("lk_rr_gnt", 32'(gnt_id), 32'h2);
`endif
        #1 wrst_n = 1'b0;
        #1;
        chk("arst_ready",  32'(req_ready), 32'h0);
        chk("arst_winc",   32'(winc),      32'h0);
        chk("arst_wcount", 32'(wcount),    32'h0);
        wrst_n = 1'b1;
        #1;
        chk("arst_rel_gnt",    32'(gnt_id),    32'h0);
        chk("arst_rel_ready",  32'(req_ready), 32'h1);
        chk("arst_rel_wcount", 32'(wcount),    32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
